// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared state codes, colour codes and helpers for the Simon
//               game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int COLOUR_W = 2;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FILL     = 4'd1;
    localparam logic [3:0] S_SHOW_ON  = 4'd2;
    localparam logic [3:0] S_SHOW_GAP = 4'd3;
    localparam logic [3:0] S_INPUT    = 4'd4;
    localparam logic [3:0] S_CHECK    = 4'd5;
    localparam logic [3:0] S_LEVEL_UP = 4'd6;
    localparam logic [3:0] S_WIN      = 4'd7;
    localparam logic [3:0] S_LOSE     = 4'd8;

    localparam logic [COLOUR_W-1:0] COL_B = 2'd0;
    localparam logic [COLOUR_W-1:0] COL_G = 2'd1;
    localparam logic [COLOUR_W-1:0] COL_R = 2'd2;
    localparam logic [COLOUR_W-1:0] COL_Y = 2'd3;

    function automatic logic [3:0] onehot4(input logic [COLOUR_W-1:0] colour);
        onehot4 = 4'b0001 << colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : simon_tick_timer
// Description : Counts tick strobes and flags the strobe that reaches the
//               programmed load value; clear restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_tick_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] load,
    output logic             done
);

    logic [CNT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (clear) begin
            r_tick_cnt <= '0;
        end else if (tick) begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    assign done = tick && (r_tick_cnt == (load - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/simon_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : simon_sequencer
// Description : Simon game controller: fills the pattern memory, replays the
//               pattern for the current level and checks player entries.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEVEL  = 8,
    parameter int ADDR_W     = 3,
    parameter int SHOW_TICKS = 4,
    parameter int GAP_TICKS  = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                tick,
    input  logic [COLOUR_W-1:0] rand_colour,
    input  logic                in_valid,
    input  logic [COLOUR_W-1:0] in_colour,
    input  logic [COLOUR_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [COLOUR_W-1:0] mem_wdata,
    output logic                in_ready,
    output logic [3:0]          led,
    output logic [3:0]          level,
    output logic [3:0]          state_code,
    output logic                win,
    output logic                lose
);

    localparam int              c_max_ticks = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int              c_cnt_w     = $clog2(c_max_ticks + 1);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(MAX_LEVEL - 1);
    localparam logic [3:0]      c_max_level = 4'(MAX_LEVEL);

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [ADDR_W-1:0] r_fill_idx;
    logic [ADDR_W-1:0] r_show_idx;
    logic [ADDR_W-1:0] r_in_idx;
    logic [3:0]        r_level;
    logic              r_hit;
    logic [ADDR_W-1:0] w_lvl_idx;
    logic              w_in_show;
    logic              w_timer_done;
    logic [c_cnt_w-1:0] w_load;

    // Index of the last pattern entry that belongs to the current level.
    assign w_lvl_idx = ADDR_W'(r_level - 4'd1);
    assign w_in_show = (r_state == S_SHOW_ON) || (r_state == S_SHOW_GAP);
    assign w_load    = (r_state == S_SHOW_ON) ? c_cnt_w'(SHOW_TICKS) : c_cnt_w'(GAP_TICKS);

    simon_tick_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_next != r_state),
        .tick   (tick && w_in_show),
        .load   (w_load),
        .done   (w_timer_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: if (start) w_next = S_FILL;
            S_FILL:     if (r_fill_idx == c_last_idx) w_next = S_SHOW_ON;
            S_SHOW_ON:  if (w_timer_done) w_next = S_SHOW_GAP;
            S_SHOW_GAP: if (w_timer_done) w_next = (r_show_idx == w_lvl_idx) ? S_INPUT : S_SHOW_ON;
            S_INPUT:    if (in_valid) w_next = S_CHECK;
            S_CHECK: begin
                if (!r_hit)                      w_next = S_LOSE;
                else if (r_in_idx == w_lvl_idx)  w_next = S_LEVEL_UP;
                else                             w_next = S_INPUT;
            end
            S_LEVEL_UP: w_next = (r_level == c_max_level) ? S_WIN : S_SHOW_ON;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill_idx <= '0;
            r_show_idx <= '0;
            r_in_idx   <= '0;
            r_level    <= '0;
            r_hit      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        r_fill_idx <= '0;
                        r_level    <= '0;
                    end
                end
                S_FILL: begin
                    if (r_fill_idx == c_last_idx) begin
                        r_level    <= 4'd1;
                        r_show_idx <= '0;
                    end else begin
                        r_fill_idx <= r_fill_idx + ADDR_W'(1);
                    end
                end
                S_SHOW_GAP: begin
                    if (w_timer_done) begin
                        if (r_show_idx == w_lvl_idx) r_in_idx   <= '0;
                        else                         r_show_idx <= r_show_idx + ADDR_W'(1);
                    end
                end
                S_INPUT: if (in_valid) r_hit <= (in_colour == mem_rdata);
                S_CHECK: if (r_hit && (r_in_idx != w_lvl_idx)) r_in_idx <= r_in_idx + ADDR_W'(1);
                S_LEVEL_UP: begin
                    if (r_level != c_max_level) begin
                        r_level    <= r_level + 4'd1;
                        r_show_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        led       = 4'b0000;
        in_ready  = 1'b0;
        case (r_state)
            S_FILL: begin
                mem_we    = 1'b1;
                mem_addr  = r_fill_idx;
                mem_wdata = rand_colour;
            end
            S_SHOW_ON: begin
                mem_addr = r_show_idx;
                led      = onehot4(mem_rdata);
            end
            S_INPUT: begin
                mem_addr = r_in_idx;
                in_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign level      = r_level;
    assign state_code = r_state;
    assign win        = (r_state == S_WIN);
    assign lose       = (r_state == S_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_simon_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_sequencer
// Description : Self-checking bench for simon_sequencer against a pattern-level
//               reference model of the game.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_sequencer;

    localparam int ST_IDLE = 0, ST_FILL = 1, ST_ON = 2, ST_GAP = 3, ST_INPUT = 4;
    localparam int ST_CHECK = 5, ST_LVLUP = 6, ST_WIN = 7, ST_LOSE = 8;
    localparam int N_SHOW = 4, N_GAP = 2, N_LEVELS = 8;

    logic       clk = 1'b0;
    logic       resetn, start, tick, in_valid;
    logic [1:0] rand_colour, in_colour, mem_rdata, mem_wdata;
    logic [2:0] mem_addr;
    logic       mem_we, in_ready, win, lose;
    logic [3:0] led, level, state_code;

    logic [1:0] mem [0:7];
    logic [1:0] pattern [0:7];
    logic [1:0] fill_stream [0:7] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
    int checks = 0;
    int errors = 0;

    simon_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .tick        (tick),
        .rand_colour (rand_colour),
        .in_valid    (in_valid),
        .in_colour   (in_colour),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .in_ready    (in_ready),
        .led         (led),
        .level       (level),
        .state_code  (state_code),
        .win         (win),
        .lose        (lose)
    );

    always #5 clk = ~clk;

    // External pattern memory: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic cyc(input logic tk, input bit noise);
        @(negedge clk);
        tick        = tk;
        start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_valid    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_colour   = 2'($urandom_range(0, 3));
        rand_colour = 2'($urandom_range(0, 3));
        #1;
    endtask

    // mode 0: fixed stream, 1: random with first colour Y, 2: random with first colour R
    task automatic new_game(input int mode);
        logic [1:0] v;
        @(negedge clk);
        start = 1'b1; tick = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < N_LEVELS; i++) begin
            @(negedge clk);
            start = 1'b0;
            v = (mode == 0) ? fill_stream[i] : 2'($urandom_range(0, 3));
            if (i == 0 && mode == 1) v = 2'd3;
            if (i == 0 && mode == 2) v = 2'd2;
            rand_colour = v;
            pattern[i]  = v;
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== 3'(i) || mem_wdata !== v) begin errors++;
                $display("FAIL fill_write[%0d] we=%b addr=%0d wdata=%0d expected we=1 addr=%0d wdata=%0d", i, mem_we, mem_addr, mem_wdata, i, v); end
            checks++; if (state_code !== 4'(ST_FILL)) begin errors++;
                $display("FAIL fill_state[%0d] got %0d expected %0d", i, state_code, ST_FILL); end
            if (i == 0) begin
                checks++; if (win !== 1'b0 || lose !== 1'b0 || level !== 4'd0) begin errors++;
                    $display("FAIL fill_start_clear win=%b lose=%b level=%0d expected 0 0 0", win, lose, level); end
            end
        end
        cyc(1'b0, 1'b0);
        checks++; if (state_code !== 4'(ST_ON) || level !== 4'd1 || mem_we !== 1'b0) begin errors++;
            $display("FAIL fill_done state=%0d level=%0d we=%b expected 2 1 0", state_code, level, mem_we); end
    endtask

    task automatic run_show(input int lvl, input bit noise);
        logic [3:0] exp_led;
        for (int idx = 0; idx < lvl; idx++) begin
            exp_led = 4'b0001 << pattern[idx];
            for (int t = 0; t < N_SHOW + N_GAP; t++) begin
                if (t >= N_SHOW) exp_led = 4'b0000;
                repeat ($urandom_range(0, 2)) begin
                    cyc(1'b0, noise);
                    checks++; if (led !== exp_led || state_code !== 4'(t < N_SHOW ? ST_ON : ST_GAP)) begin errors++;
                        $display("FAIL show_idle lvl=%0d idx=%0d strobe=%0d led=%b state=%0d expected led=%b", lvl, idx, t, led, state_code, exp_led); end
                end
                cyc(1'b1, 1'b0);
                checks++; if (led !== exp_led || state_code !== 4'(t < N_SHOW ? ST_ON : ST_GAP) || in_ready !== 1'b0) begin errors++;
                    $display("FAIL show_strobe lvl=%0d idx=%0d strobe=%0d led=%b state=%0d rdy=%b expected led=%b", lvl, idx, t, led, state_code, in_ready, exp_led); end
            end
        end
        cyc(1'b0, 1'b0);
        checks++; if (state_code !== 4'(ST_INPUT) || in_ready !== 1'b1 || led !== 4'b0000) begin errors++;
            $display("FAIL show_to_input lvl=%0d state=%0d rdy=%b led=%b expected 4 1 0000", lvl, state_code, in_ready, led); end
    endtask

    task automatic enter(input int lvl, input int wrong_at);
        logic [1:0] c;
        int exp_st;
        for (int i = 0; i < lvl; i++) begin
            c = pattern[i];
            if (i == wrong_at) c = c + 2'($urandom_range(1, 3));
            @(negedge clk);
            tick = 1'b0; start = 1'b0; in_valid = 1'b1; in_colour = c;
            #1;
            checks++; if (in_ready !== 1'b1 || state_code !== 4'(ST_INPUT)) begin errors++;
                $display("FAIL input_ready lvl=%0d i=%0d rdy=%b state=%0d expected 1 4", lvl, i, in_ready, state_code); end
            cyc(1'b0, 1'b0);
            checks++; if (state_code !== 4'(ST_CHECK) || in_ready !== 1'b0) begin errors++;
                $display("FAIL check_state lvl=%0d i=%0d state=%0d rdy=%b expected 5 0", lvl, i, state_code, in_ready); end
            exp_st = (i == wrong_at) ? ST_LOSE : (i == lvl - 1) ? ST_LVLUP : ST_INPUT;
            cyc(1'b0, 1'b0);
            checks++; if (state_code !== 4'(exp_st) || level !== 4'(lvl)) begin errors++;
                $display("FAIL check_result lvl=%0d i=%0d state=%0d level=%0d expected %0d %0d", lvl, i, state_code, level, exp_st, lvl); end
            if (i == wrong_at) return;
            if (i == lvl - 1) begin
                cyc(1'b0, 1'b0);
                checks++; if (state_code !== 4'(lvl == N_LEVELS ? ST_WIN : ST_ON) || level !== 4'(lvl == N_LEVELS ? lvl : lvl + 1)) begin errors++;
                    $display("FAIL level_up lvl=%0d state=%0d level=%0d", lvl, state_code, level); end
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; tick = 1'b0; in_valid = 1'b0;
        in_colour = 2'd0; rand_colour = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state_code !== 4'd0 || led !== 4'd0 || level !== 4'd0 || mem_addr !== 3'd0) begin errors++;
            $display("FAIL reset_outputs state=%0d led=%b level=%0d addr=%0d expected all 0", state_code, led, level, mem_addr); end
        checks++; if ({mem_we, in_ready, win, lose} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags we/rdy/win/lose=%b expected 0000", {mem_we, in_ready, win, lose}); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) cyc(1'b1, 1'b0);
        checks++; if (state_code !== 4'(ST_IDLE) || level !== 4'd0) begin errors++;
            $display("FAIL reset_idle_hold state=%0d level=%0d expected 0 0", state_code, level); end
    endtask

    task automatic test_fill_and_lose;
        new_game(0);
        run_show(1, 1'b0); enter(1, -1);
        run_show(2, 1'b0); enter(2, -1);
        run_show(3, 1'b0); enter(3, 1);
        checks++; if (lose !== 1'b1 || win !== 1'b0 || level !== 4'd3 || led !== 4'd0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL lose_outputs lose=%b win=%b level=%0d led=%b rdy=%b expected 1 0 3 0000 0", lose, win, level, led, in_ready); end
        @(negedge clk);
        in_valid = 1'b1; in_colour = pattern[1];
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        checks++; if (state_code !== 4'(ST_LOSE) || lose !== 1'b1 || level !== 4'd3) begin errors++;
            $display("FAIL lose_sticky state=%0d lose=%b level=%0d expected 8 1 3", state_code, lose, level); end
    endtask

    task automatic test_show_ignored_and_win;
        new_game(1);
        run_show(1, 1'b0); enter(1, -1);
        run_show(2, 1'b1); enter(2, -1);
        for (int l = 3; l <= N_LEVELS; l++) begin
            run_show(l, 1'($urandom_range(0, 1)));
            enter(l, -1);
        end
        checks++; if (win !== 1'b1 || lose !== 1'b0 || level !== 4'd8 || in_ready !== 1'b0) begin errors++;
            $display("FAIL win_outputs win=%b lose=%b level=%0d rdy=%b expected 1 0 8 0", win, lose, level, in_ready); end
        repeat (2) cyc(1'b1, 1'b0);
        checks++; if (state_code !== 4'(ST_WIN) || led !== 4'd0 || win !== 1'b1) begin errors++;
            $display("FAIL win_hold state=%0d led=%b win=%b expected 7 0000 1", state_code, led, win); end
    endtask

    task automatic test_reset_mid_show;
        new_game(2);
        cyc(1'b1, 1'b0);
        checks++; if (state_code !== 4'(ST_ON) || led !== 4'b0100) begin errors++;
            $display("FAIL midshow_led state=%0d led=%b expected 2 0100", state_code, led); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (state_code !== 4'(ST_IDLE) || led !== 4'd0 || level !== 4'd0) begin errors++;
            $display("FAIL async_reset state=%0d led=%b level=%0d expected 0 0000 0", state_code, led, level); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) cyc(1'b1, 1'b0);
        checks++; if (state_code !== 4'(ST_IDLE) || level !== 4'd0 || mem_we !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle state=%0d level=%0d we=%b expected 0 0 0", state_code, level, mem_we); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired CHECKS %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_and_lose();
        test_show_ignored_and_win();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
